axi_trace_recorder: RTL and testbench
=====================================

Name: axi_trace_recorder

Overview:
- Passive hardware monitor on an AXI4 AW/AR address-channel pair.
- Captures every completed address handshake as a fixed-format transaction record:
  - timestamp, direction, ID, address, len, size, burst.
- Buffers records in an internal FIFO and streams them out over a valid/ready record port.
- Feeds the testbench logging layer: it produces the records that the software side formats into size/burst strings and log lines.

Parameters:
- ADDR_WIDTH, 32, width of aw_addr/ar_addr.
- ID_WIDTH, 4, width of aw_id/ar_id.
- DEPTH, 16, record FIFO depth; power of two, at least 4.
- REC_W, 46+ID_WIDTH+ADDR_WIDTH, record width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trace_en  in  1  capture enable; 0 = no new records, readout continues
- aw_valid, aw_ready  in  1 each  monitored write address handshake
- aw_id  in  ID_WIDTH; aw_addr  in  ADDR_WIDTH; aw_len  in  8; aw_size  in  3; aw_burst  in  2
- ar_valid, ar_ready  in  1 each  monitored read address handshake
- ar_id  in  ID_WIDTH; ar_addr  in  ADDR_WIDTH; ar_len  in  8; ar_size  in  3; ar_burst  in  2
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_data  out  REC_W  record, MSB to LSB: {ts[31:0], is_write, id, addr, len[7:0], size[2:0], burst[1:0]}
- rec_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_count  out  16  records lost to overflow, saturating at 16'hFFFF
- overflow  out  1  sticky; set on any drop
- clr_drop  in  1  clears drop_count and overflow

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty; rec_valid=0; rec_data=0; rec_count=0; drop_count=0; overflow=0; timestamp counter=0.
  - Reset mid-operation discards all buffered records.
- Timestamp: 32-bit free-running counter, +1 every cycle, wraps FFFFFFFF->0.
  - A record's ts is the counter value in the handshake cycle.
- Capture event: x_valid & x_ready & trace_en sampled at a clk edge. Monitored ports are never driven.
- Push: records are written at that edge.
  - Latency: handshake at cycle N with empty FIFO -> rec_valid=1 with that record in cycle N+1.
- Both AW and AR fire in the same cycle: two pushes in one cycle.
  - AW record goes first (lower FIFO slot, same ts).
  - AR record goes second.
- Free space rules:
  - free >= 2: both records stored.
  - free == 1: AW stored, AR dropped.
  - free == 0: both dropped.
- Drop: drop_count += number dropped (saturating); overflow set.
  - clr_drop has priority over a same-cycle drop: count=0, overflow=0 that cycle.
- Readout: FWFT. rec_data is valid whenever rec_valid=1 and holds stable until rec_valid & rec_ready.
  - rec_data is a don't-care when empty; implement as last value.
- Full FIFO with simultaneous pop and push: the pop frees a slot the same cycle.
  - Free-space check uses (free + pop), so a full FIFO with a pop accepts 1 push without a drop.
- rec_count: registered occupancy after the edge's pushes and pops.
- Fields are recorded raw (no legality checks): reserved burst 2'b11 and any len/size pass through unchanged.

Optional Feature:
- Macro: AXI_TRACE_FILTER_EN.
- Defined:
  - Adds ports filt_base (in, ADDR_WIDTH) and filt_mask (in, ADDR_WIDTH).
  - A handshake is captured only if (addr & filt_mask) == (filt_base & filt_mask).
  - Filtered-out handshakes are neither stored nor counted as drops.
  - Filter is applied per channel before the free-space check.
- Undefined: no filter ports; every enabled handshake is captured.

Test Plan:
- Reset, then single AW handshake at ts=5: id=3, addr=0x1000, len=7, size=3'b010, burst=2'b01 -> cycle after: rec_valid=1, rec_data={32'd5,1'b1,4'h3,32'h1000,8'd7,3'b010,2'b01}; rec_count=1.
- AW and AR fire in the same cycle -> two records with identical ts: AW (is_write=1) popped first, then AR (is_write=0); rec_count=2.
- rec_ready=0, 18 single AR handshakes, DEPTH=16 -> rec_count=16, drop_count=2, overflow=1. Pulse clr_drop -> drop_count=0, overflow=0, rec_count=16.
- FIFO full, rec_ready=1 and one AR handshake in the same cycle -> no drop, rec_count stays 16. FIFO at 15 with AW+AR together -> AW stored, AR dropped, drop_count=1.
- trace_en=0 with 10 handshakes -> no records; then rst asserted with 5 queued -> next cycle rec_valid=0, rec_count=0, ts=0.
- With AXI_TRACE_FILTER_EN, filt_base=0x2000, filt_mask=0xF000: handshakes at 0x2010 and 0x3010 -> only the 0x2010 record appears; drop_count=0.

Source files
------------

// File: rtl/axi_trace_recorder.sv
// Passive AXI4 AW/AR address-channel recorder: one record per captured handshake, held in a FWFT FIFO.
// Optional address filter is compiled in by defining AXI_TRACE_FILTER_EN.
module axi_trace_recorder #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 16,
    parameter int REC_W      = 46 + ID_WIDTH + ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en,
    input  logic                   aw_valid,
    input  logic                   aw_ready,
    input  logic [ID_WIDTH-1:0]    aw_id,
    input  logic [ADDR_WIDTH-1:0]  aw_addr,
    input  logic [7:0]             aw_len,
    input  logic [2:0]             aw_size,
    input  logic [1:0]             aw_burst,
    input  logic                   ar_valid,
    input  logic                   ar_ready,
    input  logic [ID_WIDTH-1:0]    ar_id,
    input  logic [ADDR_WIDTH-1:0]  ar_addr,
    input  logic [7:0]             ar_len,
    input  logic [2:0]             ar_size,
    input  logic [1:0]             ar_burst,
`ifdef AXI_TRACE_FILTER_EN
    input  logic [ADDR_WIDTH-1:0]  filt_base,
    input  logic [ADDR_WIDTH-1:0]  filt_mask,
`endif
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [REC_W-1:0]       rec_data,
    output logic [$clog2(DEPTH):0] rec_count,
    output logic [15:0]            drop_count,
    output logic                   overflow,
    input  logic                   clr_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      ts_q;
    logic [REC_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [REC_W-1:0] recData_q, recData_d;
    logic [15:0]      dropCount_q, dropCount_d;
    logic             overflow_q, overflow_d;

    logic             awMatch, arMatch;
    logic             awFire, arFire;
    logic             pop;
    logic             storeAw, storeAr;
    logic [CW:0]      avail;
    logic [1:0]       nDrop;
    logic [CW-1:0]    nPush;
    logic [CW-1:0]    remaining;
    logic [PW-1:0]    arSlot;
    logic [16:0]      dropSum;
    logic [REC_W-1:0] awRec, arRec;

`ifdef AXI_TRACE_FILTER_EN
    assign awMatch = ((aw_addr & filt_mask) == (filt_base & filt_mask));
    assign arMatch = ((ar_addr & filt_mask) == (filt_base & filt_mask));
`else
    assign awMatch = 1'b1;
    assign arMatch = 1'b1;
`endif

    assign awFire = aw_valid & aw_ready & trace_en & awMatch;
    assign arFire = ar_valid & ar_ready & trace_en & arMatch;
    assign awRec  = {ts_q, 1'b1, aw_id, aw_addr, aw_len, aw_size, aw_burst};
    assign arRec  = {ts_q, 1'b0, ar_id, ar_addr, ar_len, ar_size, ar_burst};

    assign rec_valid  = (count_q != '0);
    assign pop        = rec_valid & rec_ready;
    assign rec_data   = recData_q;
    assign rec_count  = count_q;
    assign drop_count = dropCount_q;
    assign overflow   = overflow_q;

    // A same-cycle pop frees its slot before the pushes are checked for room.
    assign avail = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};

    always_comb begin
        storeAw     = awFire && (avail != '0);
        storeAr     = arFire && (storeAw ? (avail >= (CW+1)'(2)) : (avail != '0));
        nDrop       = {1'b0, awFire & ~storeAw} + {1'b0, arFire & ~storeAr};
        nPush       = CW'(storeAw) + CW'(storeAr);
        count_d     = count_q + nPush - CW'(pop);
        remaining   = count_q - CW'(pop);
        arSlot      = wrPtr_q + PW'(storeAw);
        dropSum     = {1'b0, dropCount_q} + {15'd0, nDrop};
        recData_d   = recData_q;
        dropCount_d = dropCount_q;
        overflow_d  = overflow_q;

        // The output register always tracks the head; if the FIFO drains empty it keeps its last value.
        if (count_d != '0) begin
            if (remaining == '0) begin
                recData_d = storeAw ? awRec : arRec;
            end else begin
                recData_d = mem_q[rdPtr_q + PW'(pop)];
            end
        end

        if (clr_drop) begin
            dropCount_d = '0;
            overflow_d  = 1'b0;
        end else if (nDrop != '0) begin
            dropCount_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
            overflow_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q        <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            recData_q   <= '0;
            dropCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ts_q        <= ts_q + 32'd1;
            wrPtr_q     <= wrPtr_q + PW'(nPush);
            rdPtr_q     <= rdPtr_q + PW'(pop);
            count_q     <= count_d;
            recData_q   <= recData_d;
            dropCount_q <= dropCount_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (storeAw) mem_q[wrPtr_q] <= awRec;
            if (storeAr) mem_q[arSlot]  <= arRec;
        end
    end
endmodule

// File: tb/tb_axi_trace_recorder.sv
// Scoreboard bench for axi_trace_recorder: queue-based reference model, directed plus random traffic.
// Filter cases run only when AXI_TRACE_FILTER_EN is defined.
module tb_axi_trace_recorder;
    localparam int ADDR_WIDTH = 32;
    localparam int ID_WIDTH   = 4;
    localparam int DEPTH      = 16;
    localparam int REC_W      = 46 + ID_WIDTH + ADDR_WIDTH;
    localparam int CW         = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } chan_t;

    logic clk = 1'b0;
    logic rst, trace_en, rec_ready, clr_drop;
    logic aw_valid, aw_ready, ar_valid, ar_ready;
    logic [ID_WIDTH-1:0]   aw_id, ar_id;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [7:0] aw_len, ar_len;
    logic [2:0] aw_size, ar_size;
    logic [1:0] aw_burst, ar_burst;
    logic             rec_valid;
    logic [REC_W-1:0] rec_data;
    logic [CW-1:0]    rec_count;
    logic [15:0]      drop_count;
    logic             overflow;
`ifdef AXI_TRACE_FILTER_EN
    logic [ADDR_WIDTH-1:0] filt_base, filt_mask;
`endif

    int total = 0;
    int bad = 0;
    logic [REC_W-1:0] expQ[$];
    int          modelCount;
    int          modelDrops;
    bit          modelOvf;
    logic [31:0] tsModel;
    bit          modelReady = 0;
    chan_t       idle = '0;
    logic [REC_W-1:0] expRec;

    always #5 clk = ~clk;

    axi_trace_recorder #(.ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
`ifdef AXI_TRACE_FILTER_EN
        .filt_base(filt_base), .filt_mask(filt_mask),
`endif
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .rec_count(rec_count), .drop_count(drop_count), .overflow(overflow),
        .clr_drop(clr_drop)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        check("rec_count", rec_count, modelCount);
        check("drop_count", drop_count, modelDrops);
        check("overflow", overflow, modelOvf);
        check("rec_valid", rec_valid, modelCount != 0);
    endtask

    function automatic chan_t mkChan(input logic v, input logic r, input int id, input logic [31:0] addr,
                                     input int len, input int size, input int burst);
        chan_t c;
        c.valid = v; c.ready = r; c.id = ID_WIDTH'(id); c.addr = addr;
        c.len = 8'(len); c.size = 3'(size); c.burst = 2'(burst);
        return c;
    endfunction

    function automatic chan_t randChan(input int pct);
        return mkChan($urandom_range(0, 99) < pct, $urandom_range(0, 99) < 70, $urandom_range(0, 15),
                      $urandom, $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 3));
    endfunction

    function automatic bit captured(input chan_t c, input logic en);
        bit hit = en && c.valid && c.ready;
`ifdef AXI_TRACE_FILTER_EN
        hit = hit && ((c.addr & filt_mask) == (filt_base & filt_mask));
`endif
        return hit;
    endfunction

    // One call per clock cycle: drives the inputs for the coming edge and applies the same edge to the model.
    task automatic applyStimulus(input chan_t aw, input chan_t ar, input logic en, input logic rdy,
                                 input logic clr, input logic rs);
        int  avail;
        int  dropped;
        bit  pop;
        @(negedge clk);
        if (modelReady) checkOutput();
        trace_en = en; rec_ready = rdy; clr_drop = clr; rst = rs;
        aw_valid = aw.valid; aw_ready = aw.ready; aw_id = aw.id; aw_addr = aw.addr;
        aw_len = aw.len; aw_size = aw.size; aw_burst = aw.burst;
        ar_valid = ar.valid; ar_ready = ar.ready; ar_id = ar.id; ar_addr = ar.addr;
        ar_len = ar.len; ar_size = ar.size; ar_burst = ar.burst;
        if (rs) begin
            expQ.delete();
            modelCount = 0; modelDrops = 0; modelOvf = 0; tsModel = '0; modelReady = 1;
        end else begin
            pop = (modelCount > 0) && rdy;
            avail = DEPTH - modelCount + int'(pop);
            dropped = 0;
            if (captured(aw, en)) begin
                if (avail > 0) begin
                    expQ.push_back({tsModel, 1'b1, aw.id, aw.addr, aw.len, aw.size, aw.burst});
                    avail--; modelCount++;
                end else dropped++;
            end
            if (captured(ar, en)) begin
                if (avail > 0) begin
                    expQ.push_back({tsModel, 1'b0, ar.id, ar.addr, ar.len, ar.size, ar.burst});
                    avail--; modelCount++;
                end else dropped++;
            end
            modelCount -= int'(pop);
            if (clr) begin
                modelDrops = 0; modelOvf = 0;
            end else if (dropped > 0) begin
                modelDrops = (modelDrops + dropped > 65535) ? 65535 : modelDrops + dropped;
                modelOvf = 1;
            end
            tsModel = tsModel + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(idle, idle, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((modelCount != 0) && (n < 64)) begin
            applyStimulus(idle, idle, 1'b1, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check("drain_valid", rec_valid, 1'b0);
        check("drain_pending", expQ.size(), 0);
    endtask

    // Monitor: every accepted record is compared against the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b0 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL rec_unexpected: got %0h expected none", rec_data);
                end else begin
                    expRec = expQ.pop_front();
                    if (rec_data !== expRec) begin
                        bad++;
                        $display("[TB] FAIL rec_data: got %0h expected %0h", rec_data, expRec);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; trace_en = 1'b0; rec_ready = 1'b0; clr_drop = 1'b0;
        {aw_valid, aw_ready, aw_id, aw_addr, aw_len, aw_size, aw_burst} = '0;
        {ar_valid, ar_ready, ar_id, ar_addr, ar_len, ar_size, ar_burst} = '0;
`ifdef AXI_TRACE_FILTER_EN
        filt_base = '0; filt_mask = '0;
`endif
        $display("[TB] start");
        applyStimulus(idle, idle, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(idle, idle, 1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_valid", rec_valid, 1'b0);
        check("reset_data", rec_data, '0);
        check("reset_count", rec_count, 0);
        check("reset_drops", drop_count, 0);
        check("reset_ovf", overflow, 1'b0);

        // Single AW handshake in the ts=5 cycle.
        idleCycles(5, 1'b0);
        applyStimulus(mkChan(1, 1, 3, 32'h1000, 7, 2, 1), idle, 1'b1, 1'b0, 1'b0, 1'b0);
        expRec = {32'd5, 1'b1, 4'h3, 32'h1000, 8'd7, 3'b010, 2'b01};
        check("single_aw_data", rec_data, expRec);
        check("single_aw_valid", rec_valid, 1'b1);
        check("single_aw_count", rec_count, 1);
        drain();

        // AW and AR together: AW leaves first, both share a timestamp.
        applyStimulus(mkChan(1, 1, 5, 32'hA0, 1, 3, 2), mkChan(1, 1, 6, 32'hB0, 2, 1, 3),
                      1'b1, 1'b0, 1'b0, 1'b0);
        check("pair_count", rec_count, 2);
        check("pair_first_write", rec_data[REC_W-33], 1'b1);
        applyStimulus(idle, idle, 1'b1, 1'b1, 1'b0, 1'b0);
        check("pair_second_read", rec_data[REC_W-33], 1'b0);
        drain();

        // Overflow with 18 AR handshakes, then clear.
        for (int i = 0; i < 18; i++)
            applyStimulus(idle, mkChan(1, 1, i, 32'h4000 + 32'(i * 4), i, 2, 1), 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_count", rec_count, 16);
        check("full_drops", drop_count, 2);
        check("full_ovf", overflow, 1'b1);
        applyStimulus(idle, idle, 1'b1, 1'b0, 1'b1, 1'b0);
        check("clr_drops", drop_count, 0);
        check("clr_ovf", overflow, 1'b0);
        check("clr_count", rec_count, 16);
        applyStimulus(idle, mkChan(1, 1, 9, 32'h5000, 0, 0, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        check("full_pop_push_count", rec_count, 16);
        check("full_pop_push_drops", drop_count, 0);
        applyStimulus(idle, idle, 1'b1, 1'b1, 1'b0, 1'b0);
        check("at15_count", rec_count, 15);
        applyStimulus(mkChan(1, 1, 1, 32'h6000, 3, 1, 1), mkChan(1, 1, 2, 32'h7000, 4, 2, 2),
                      1'b1, 1'b0, 1'b0, 1'b0);
        check("at15_pair_count", rec_count, 16);
        check("at15_pair_drops", drop_count, 1);
        drain();

        // Capture disabled, then reset with records queued.
        for (int i = 0; i < 10; i++)
            applyStimulus(randChan(100), randChan(100), 1'b0, 1'b1, 1'b0, 1'b0);
        check("disabled_count", rec_count, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(mkChan(1, 1, i, 32'h8000 + 32'(i), 0, 0, 0), idle, 1'b1, 1'b0, 1'b0, 1'b0);
        check("queued5_count", rec_count, 5);
        applyStimulus(idle, idle, 1'b1, 1'b1, 1'b0, 1'b1);
        check("midreset_valid", rec_valid, 1'b0);
        check("midreset_count", rec_count, 0);
        check("midreset_drops", drop_count, 0);
        applyStimulus(mkChan(1, 1, 4, 32'h9000, 1, 1, 1), idle, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_ts", rec_data[REC_W-1 -: 32], 32'd0);
        drain();

        // Random traffic with varying back-pressure.
        for (int i = 0; i < 400; i++)
            applyStimulus(randChan(60), randChan(60), $urandom_range(0, 9) != 0,
                          $urandom_range(0, 99) < ((i < 200) ? 30 : 75),
                          $urandom_range(0, 29) == 0, 1'b0);
        drain();

`ifdef AXI_TRACE_FILTER_EN
        applyStimulus(idle, idle, 1'b1, 1'b1, 1'b1, 1'b0);
        filt_base = 32'h2000; filt_mask = 32'hF000;
        applyStimulus(mkChan(1, 1, 1, 32'h2010, 0, 2, 1), idle, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(mkChan(1, 1, 2, 32'h3010, 0, 2, 1), idle, 1'b1, 1'b0, 1'b0, 1'b0);
        check("filter_count", rec_count, 1);
        check("filter_drops", drop_count, 0);
        check("filter_addr", rec_data[13 +: ADDR_WIDTH], 32'h2010);
        for (int i = 0; i < 60; i++)
            applyStimulus(randChan(70), mkChan(1, 1, i, 32'h2000 + 32'($urandom_range(0, 1)) * 32'h1000, 0, 0, 0),
                          1'b1, $urandom_range(0, 1), 1'b0, 1'b0);
        drain();
        filt_mask = '0;
`endif

        applyStimulus(idle, idle, 1'b1, 1'b1, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
